audio_codec_cfg: RTL and testbench

Power-up configuration sequencer for the WM8731 audio codec. It feeds the audio shifter's serial output path.
After reset it writes a fixed 10-entry register table over a write-only I2C master (open-drain SDA, push-pull SCL), retrying NACKed transfers.
It sits in audio_top beside audio_shifter and drives the i2c_sclk/i2c_sdat pins.
It reports busy, done and error status to the host.

---
 rtl/audio_cfg_pkg.sv | 53 +++++
 rtl/audio_codec_cfg_qtick.sv | 35 +++
 rtl/audio_codec_cfg.sv | 230 +++++++++++++++++++++++
 tb/tb_audio_codec_cfg.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_cfg_pkg.sv
// +----------------------------------------------------------------------------+
// | audio_cfg_pkg : shared types and WM8731 power-up register table             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package audio_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_GAP   = 3'd5,
        ST_DONE  = 3'd6
    } cfg_state_t;

    localparam int NUM_REGS       = 10;
    localparam int BITS_PER_BYTE  = 8;
    localparam int BYTES_PER_XFER = 3;

    localparam logic [6:0] R_LLIN   = 7'h00;
    localparam logic [6:0] R_RLIN   = 7'h01;
    localparam logic [6:0] R_LHP    = 7'h02;
    localparam logic [6:0] R_RHP    = 7'h03;
    localparam logic [6:0] R_APATH  = 7'h04;
    localparam logic [6:0] R_DPATH  = 7'h05;
    localparam logic [6:0] R_PWR    = 7'h06;
    localparam logic [6:0] R_IFACE  = 7'h07;
    localparam logic [6:0] R_ACTIVE = 7'h09;
    localparam logic [6:0] R_RESET  = 7'h0F;

    function automatic logic [15:0] mk_word(input logic [6:0] addr, input logic [8:0] data);
        return {addr, data};
    endfunction

    localparam logic [15:0] CFG_TABLE [0:NUM_REGS-1] = '{
        mk_word(R_RESET,  9'h000),
        mk_word(R_LLIN,   9'h017),
        mk_word(R_RLIN,   9'h017),
        mk_word(R_LHP,    9'h079),
        mk_word(R_RHP,    9'h079),
        mk_word(R_APATH,  9'h010),
        mk_word(R_DPATH,  9'h000),
        mk_word(R_PWR,    9'h000),
        mk_word(R_IFACE,  9'h002),
        mk_word(R_ACTIVE, 9'h001)
    };

endpackage

`default_nettype wire

// File: rtl/audio_codec_cfg_qtick.sv
// +----------------------------------------------------------------------------+
// | i2c_qtick_gen : quarter-SCL-period tick generator with synchronous restart  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module i2c_qtick_gen #(
    parameter int CLK_DIV = 70
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    output logic o_qtick
);

    localparam int             CW     = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  C_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == C_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_qtick = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/audio_codec_cfg.sv
// +----------------------------------------------------------------------------+
// | audio_codec_cfg : WM8731 power-up sequencer over a write-only I2C master    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module audio_codec_cfg
    import audio_cfg_pkg::*;
#(
    parameter int         CLK_DIV    = 70,
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         MAX_RETRY  = 3,
    parameter int         GAP_Q      = 8,
    parameter int         AUTO_START = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [3:0] err_idx
);

    localparam int             RW          = $clog2(MAX_RETRY + 2);
    localparam int             GW          = $clog2(GAP_Q + 1);
    localparam logic [RW-1:0]  C_MAX_RETRY = RW'(MAX_RETRY);
    localparam logic [GW-1:0]  C_GAP_LAST  = GW'(GAP_Q - 1);
    localparam logic [3:0]     C_LAST_IDX  = 4'(NUM_REGS - 1);
    localparam logic [2:0]     C_LAST_BIT  = 3'(BITS_PER_BYTE - 1);
    localparam logic [1:0]     C_LAST_BYTE = 2'(BYTES_PER_XFER - 1);

    cfg_state_t    r_state, w_state_n;
    logic [1:0]    r_q, w_q_n;
    logic [2:0]    r_bit, w_bit_n;
    logic [1:0]    r_byte, w_byte_n;
    logic [3:0]    r_idx, w_idx_n;
    logic [RW-1:0] r_retry, w_retry_n;
    logic [GW-1:0] r_gap, w_gap_n;
    logic          r_nack, w_nack_n;
    logic          r_scl, w_scl_n;
    logic          r_sda_low, w_sda_low_n;
    logic          r_done, w_done_n;
    logic          r_ack_err, w_ack_err_n;
    logic [3:0]    r_err_idx, w_err_idx_n;
    logic          r_auto, w_auto_n;
    logic [1:0]    r_sda_sync;
    logic          w_go, w_qtick, w_busy;
    logic [15:0]   w_word;
    logic [7:0]    w_tx_byte;

    i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_go),
        .o_qtick   (w_qtick)
    );

    assign w_busy = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_word = CFG_TABLE[r_idx];

    always_comb begin
        case (r_byte)
            2'd0:    w_tx_byte = {DEV_ADDR, 1'b0};
            2'd1:    w_tx_byte = w_word[15:8];
            default: w_tx_byte = w_word[7:0];
        endcase
    end

    always_comb begin
        w_state_n   = r_state;
        w_q_n       = r_q;
        w_bit_n     = r_bit;
        w_byte_n    = r_byte;
        w_idx_n     = r_idx;
        w_retry_n   = r_retry;
        w_gap_n     = r_gap;
        w_nack_n    = r_nack;
        w_scl_n     = r_scl;
        w_sda_low_n = r_sda_low;
        w_done_n    = r_done;
        w_ack_err_n = r_ack_err;
        w_err_idx_n = r_err_idx;
        w_auto_n    = r_auto;
        w_go        = 1'b0;
        if ((r_state == ST_IDLE && (start || r_auto)) || (r_state == ST_DONE && start)) begin
            w_go        = 1'b1;
            w_state_n   = ST_START;
            w_q_n       = 2'd0;
            w_idx_n     = 4'd0;
            w_retry_n   = '0;
            w_done_n    = 1'b0;
            w_ack_err_n = 1'b0;
            w_err_idx_n = 4'd0;
            w_auto_n    = 1'b0;
        end else if (w_qtick && w_busy) begin
            if (r_state != ST_GAP) begin
                w_q_n = r_q + 2'd1;
            end
            case (r_state)
                ST_START: begin
                    case (r_q)
                        2'd0: begin w_scl_n = 1'b1; w_sda_low_n = 1'b0; end
                        2'd1: w_sda_low_n = 1'b1;
                        2'd2: ;
                        default: begin
                            w_scl_n   = 1'b0;
                            w_state_n = ST_BIT;
                            w_bit_n   = 3'd0;
                            w_byte_n  = 2'd0;
                            w_nack_n  = 1'b0;
                        end
                    endcase
                end
                ST_BIT: begin
                    case (r_q)
                        2'd0: begin w_scl_n = 1'b0; w_sda_low_n = ~w_tx_byte[C_LAST_BIT - r_bit]; end
                        2'd1: w_scl_n = 1'b1;
                        2'd2: ;
                        default: begin
                            w_scl_n = 1'b0;
                            if (r_bit == C_LAST_BIT) w_state_n = ST_ACK;
                            else                     w_bit_n   = r_bit + 3'd1;
                        end
                    endcase
                end
                ST_ACK: begin
                    case (r_q)
                        2'd0: begin w_scl_n = 1'b0; w_sda_low_n = 1'b0; end
                        2'd1: w_scl_n = 1'b1;
                        2'd2: w_nack_n = r_sda_sync[1];
                        default: begin
                            w_scl_n = 1'b0;
                            // A NACK on any byte abandons the rest of the frame.
                            if (r_nack || r_byte == C_LAST_BYTE) begin
                                w_state_n = ST_STOP;
                            end else begin
                                w_state_n = ST_BIT;
                                w_byte_n  = r_byte + 2'd1;
                                w_bit_n   = 3'd0;
                            end
                        end
                    endcase
                end
                ST_STOP: begin
                    case (r_q)
                        2'd0: begin w_scl_n = 1'b0; w_sda_low_n = 1'b1; end
                        2'd1: w_scl_n = 1'b1;
                        2'd2: w_sda_low_n = 1'b0;
                        default: begin w_state_n = ST_GAP; w_gap_n = '0; end
                    endcase
                end
                ST_GAP: begin
                    if (r_gap == C_GAP_LAST) begin
                        w_gap_n = '0;
                        if (r_nack && r_retry < C_MAX_RETRY) begin
                            w_retry_n = r_retry + 1'b1;
                            w_state_n = ST_START;
                        end else begin
                            // Only the first exhausted entry is reported.
                            if (r_nack) begin
                                w_ack_err_n = 1'b1;
                                if (!r_ack_err) w_err_idx_n = r_idx;
                            end
                            w_retry_n = '0;
                            if (r_idx == C_LAST_IDX) begin
                                w_state_n = ST_DONE;
                                w_done_n  = 1'b1;
                            end else begin
                                w_idx_n   = r_idx + 4'd1;
                                w_state_n = ST_START;
                            end
                        end
                    end else begin
                        w_gap_n = r_gap + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_q        <= 2'd0;
            r_bit      <= 3'd0;
            r_byte     <= 2'd0;
            r_idx      <= 4'd0;
            r_retry    <= '0;
            r_gap      <= '0;
            r_nack     <= 1'b0;
            r_scl      <= 1'b1;
            r_sda_low  <= 1'b0;
            r_done     <= 1'b0;
            r_ack_err  <= 1'b0;
            r_err_idx  <= 4'd0;
            r_auto     <= (AUTO_START != 0);
            r_sda_sync <= 2'b11;
        end else begin
            r_state    <= w_state_n;
            r_q        <= w_q_n;
            r_bit      <= w_bit_n;
            r_byte     <= w_byte_n;
            r_idx      <= w_idx_n;
            r_retry    <= w_retry_n;
            r_gap      <= w_gap_n;
            r_nack     <= w_nack_n;
            r_scl      <= w_scl_n;
            r_sda_low  <= w_sda_low_n;
            r_done     <= w_done_n;
            r_ack_err  <= w_ack_err_n;
            r_err_idx  <= w_err_idx_n;
            r_auto     <= w_auto_n;
            r_sda_sync <= {r_sda_sync[0], i2c_sdat};
        end
    end

    assign i2c_sclk = r_scl;
    assign i2c_sdat = r_sda_low ? 1'b0 : 1'bz;
    assign busy     = w_busy;
    assign done     = r_done;
    assign ack_err  = r_ack_err;
    assign err_idx  = r_err_idx;

endmodule

`default_nettype wire

// File: tb/tb_audio_codec_cfg.sv
// +----------------------------------------------------------------------------+
// | tb_audio_codec_cfg : directed bench with an I2C slave model on the bus      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_audio_codec_cfg;

    localparam int CLK_DIV   = 4;
    localparam int GAP_Q     = 8;
    localparam int MAX_RETRY = 3;
    localparam int CLEAN_CYC = 1 + CLK_DIV * 10 * (116 + GAP_Q);
    localparam int LIMIT     = 20000;

    localparam int S_IDLE  = 0;
    localparam int S_BYTE  = 1;
    localparam int S_AFALL = 2;
    localparam int S_ACLK  = 3;
    localparam int S_WSTOP = 4;

    typedef struct {
        int lo;
        int hi;
        int attempts;
        int err;
        int idx;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       slv_clr = 1'b0;
    logic       slv_low = 1'b0;
    wire        scl;
    wire        sda;
    logic       busy, done, ack_err;
    logic [3:0] err_idx;

    int n_vec = 0;
    int n_err = 0;

    pullup (sda);
    assign sda = slv_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    audio_codec_cfg #(
        .CLK_DIV    (CLK_DIV),
        .DEV_ADDR   (7'h1A),
        .MAX_RETRY  (MAX_RETRY),
        .GAP_Q      (GAP_Q),
        .AUTO_START (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .i2c_sclk (scl),
        .i2c_sdat (sda),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .err_idx  (err_idx)
    );

    // Slave: oversamples the bus, ACKs every byte except the address byte of
    // attempts numbered in [nack_lo, nack_hi).
    int         nack_lo = 0, nack_hi = 0;
    int         s_st, bitc, bytec, attempts, rx_done, nacks, stops;
    logic       p_scl, p_sda, cur_nack, s_ack, got_nack;
    logic [7:0] sh;
    logic [7:0] rx0 [0:31];
    logic [7:0] rx1 [0:31];
    logic [7:0] rx2 [0:31];

    always @(posedge clk) begin
        if (!rst_n || slv_clr) begin
            s_st <= S_IDLE; bitc <= 0; bytec <= 0; attempts <= 0; rx_done <= 0;
            nacks <= 0; stops <= 0; p_scl <= 1'b1; p_sda <= 1'b1; cur_nack <= 1'b0;
            s_ack <= 1'b1; got_nack <= 1'b0; sh <= 8'h00; slv_low <= 1'b0;
        end else begin
            p_scl <= scl;
            p_sda <= sda;
            if (p_scl && scl && p_sda && !sda) begin
                s_st     <= S_BYTE;
                bitc     <= 0;
                bytec    <= 0;
                got_nack <= 1'b0;
                cur_nack <= (attempts >= nack_lo) && (attempts < nack_hi);
                attempts <= attempts + 1;
            end else if (p_scl && scl && !p_sda && sda) begin
                if (s_st == S_WSTOP && got_nack) stops <= stops + 1;
                s_st <= S_IDLE;
            end else begin
                case (s_st)
                    S_BYTE: if (!p_scl && scl) begin
                        sh <= {sh[6:0], sda};
                        if (bitc == 7) s_st <= S_AFALL;
                        else           bitc <= bitc + 1;
                    end
                    S_AFALL: if (p_scl && !scl) begin
                        s_ack   <= !(bytec == 0 && cur_nack);
                        slv_low <= !(bytec == 0 && cur_nack);
                        if (bytec == 0 && cur_nack) nacks <= nacks + 1;
                        if (rx_done < 32) begin
                            case (bytec)
                                0:       rx0[rx_done] <= sh;
                                1:       rx1[rx_done] <= sh;
                                default: rx2[rx_done] <= sh;
                            endcase
                        end
                        s_st <= S_ACLK;
                    end
                    S_ACLK: if (p_scl && !scl) begin
                        slv_low <= 1'b0;
                        if (!s_ack) begin
                            got_nack <= 1'b1;
                            s_st     <= S_WSTOP;
                        end else if (bytec == 2) begin
                            rx_done <= rx_done + 1;
                            s_st    <= S_WSTOP;
                        end else begin
                            bytec <= bytec + 1;
                            bitc  <= 0;
                            s_st  <= S_BYTE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [15:0] tbl [0:9];
    int          exp_ent [0:15];
    int          exp_n;
    vec_t        vecs [0:4];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Retry rule applied to an attempt-indexed NACK window.
    function automatic void build_exp(input int lo, input int hi);
        int t;
        bit nk;
        t = 0;
        exp_n = 0;
        for (int e = 0; e < 10; e++) begin
            for (int a = 0; a <= MAX_RETRY; a++) begin
                nk = (t >= lo) && (t < hi);
                t++;
                if (!nk) begin
                    exp_ent[exp_n] = e;
                    exp_n++;
                    break;
                end
            end
        end
    endfunction

    task automatic run_to_done(input int pulse_at, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == pulse_at);
        end while (done !== 1'b1 && cyc < LIMIT);
        chk("done_reached", done, 1);
    endtask

    task automatic chk_bytes(input int n);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = tbl[exp_ent[i]];
            chk($sformatf("tx%0d_addr", i), rx0[i], 8'h34);
            chk($sformatf("tx%0d_hi", i), rx1[i], w[15:8]);
            chk($sformatf("tx%0d_lo", i), rx2[i], w[7:0]);
        end
    endtask

    initial begin
        int cyc;
        int k;
        tbl = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                16'h0810, 16'h0A00, 16'h0C00, 16'h0E02, 16'h1201};
        vecs[0] = '{lo: 0, hi: 0,  attempts: 10, err: 0, idx: 0};
        vecs[1] = '{lo: 2, hi: 3,  attempts: 11, err: 0, idx: 0};
        vecs[2] = '{lo: 3, hi: 7,  attempts: 13, err: 1, idx: 3};
        vecs[3] = '{lo: 9, hi: 13, attempts: 13, err: 1, idx: 9};
        vecs[4] = '{lo: 1, hi: 9,  attempts: 16, err: 1, idx: 1};

        for (int v = 0; v < 5; v++) begin
            nack_lo = vecs[v].lo;
            nack_hi = vecs[v].hi;
            rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("rst_scl", scl, 1);
            chk("rst_sda", sda, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_ack_err", ack_err, 0);
            chk("rst_err_idx", err_idx, 0);
            @(negedge clk);
            rst_n = 1'b1;
            run_to_done(0, cyc);
            if (vecs[v].lo == vecs[v].hi) chk("done_cycles", cyc, CLEAN_CYC);
            chk("busy_end", busy, 0);
            chk("attempts", attempts, vecs[v].attempts);
            chk("ack_err", ack_err, vecs[v].err);
            chk("err_idx", err_idx, vecs[v].idx);
            chk("nack_count", nacks, vecs[v].hi - vecs[v].lo);
            chk("stop_after_nack", stops, vecs[v].hi - vecs[v].lo);
            build_exp(vecs[v].lo, vecs[v].hi);
            chk("completed", rx_done, exp_n);
            chk_bytes(exp_n);
        end

        // Start in DONE after an error run clears status and restarts at entry 0.
        nack_lo = 0;
        nack_hi = 0;
        slv_clr = 1'b1;
        @(posedge clk); #1;
        slv_clr = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart_done_clr", done, 0);
        chk("restart_err_clr", ack_err, 0);
        chk("restart_idx_clr", err_idx, 0);
        chk("restart_busy", busy, 1);
        run_to_done(0, cyc);
        chk("restart_completed", rx_done, 10);
        chk("restart_ack_err", ack_err, 0);
        build_exp(0, 0);
        chk_bytes(1);

        // Start pulse while busy must not disturb the sequence.
        slv_clr = 1'b1;
        @(posedge clk); #1;
        slv_clr = 1'b0;
        start = 1'b1;
        run_to_done(2000, cyc);
        chk("busy_pulse_cycles", cyc, CLEAN_CYC);
        chk("busy_pulse_attempts", attempts, 10);
        chk("busy_pulse_completed", rx_done, 10);

        // Asynchronous reset in the middle of entry 5's register byte.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (!(attempts == 6 && s_st == S_BYTE && bytec == 1 && bitc == 2 && scl == 1'b0) && k < LIMIT) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_entry5", (k < LIMIT), 1);
        chk("pre_rst_sda", sda, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_scl", scl, 1);
        chk("async_rst_sda", sda, 1);
        chk("async_rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_to_done(0, cyc);
        chk("rerun_cycles", cyc, CLEAN_CYC);
        chk("rerun_attempts", attempts, 10);
        chk("rerun_completed", rx_done, 10);
        build_exp(0, 0);
        chk_bytes(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
